// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over W steps, then a sign-fix cycle.
module mdu_seq #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   mdu_op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;    // product or quotient must be negated
  logic             neg_r;    // remainder must be negated
  logic [W-1:0]     opb;      // multiplicand or divisor magnitude
  logic [W-1:0]     acc_h;    // product high half / partial remainder
  logic [W-1:0]     acc_l;    // multiplier shifting out, quotient shifting in

  // Issue-time operand conditioning
  logic         signed_op;
  logic         rs_neg;
  logic         rt_neg;
  logic [W-1:0] rs_mag;
  logic [W-1:0] rt_mag;

  // One iteration of each algorithm
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic         div_ok;
  logic [W-1:0] div_diff;

  // Final sign correction
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    signed_op = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    rs_neg    = signed_op && rs_val[W-1];
    rt_neg    = signed_op && rt_val[W-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_h} + (acc_l[0] ? {1'b0, opb} : {(W+1){1'b0}});
    div_shift = {acc_h, acc_l[W-1]};
    div_ok    = (div_shift >= {1'b0, opb});
    // Only consumed when div_ok, where the true difference is below opb and fits W bits.
    div_diff  = div_shift[W-1:0] - opb;
  end

  always_comb begin
    prod_fix = neg_q ? -{acc_h, acc_l} : {acc_h, acc_l};
    quo_fix  = neg_q ? -acc_l : acc_l;
    rem_fix  = neg_r ? -acc_h : acc_h;
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc_h  <= '0;
      acc_l  <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                is_div <= 1'b0;
                neg_q  <= rs_neg ^ rt_neg;
                neg_r  <= rs_neg;
                opb    <= rs_mag;
                acc_h  <= '0;
                acc_l  <= rt_mag;
                cnt    <= '0;
                state  <= S_CALC;
              end
              OP_DIV, OP_DIVU: begin
                is_div <= 1'b1;
                opb    <= rt_mag;
                cnt    <= '0;
                if (rt_val == '0) begin
                  // Divide by zero: preload the architectural result and let FIX write it unsigned.
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  acc_h <= rs_val;
                  acc_l <= '1;
                  state <= S_FIX;
                end else begin
                  neg_q <= rs_neg ^ rt_neg;
                  neg_r <= rs_neg;
                  acc_h <= '0;
                  acc_l <= rs_mag;
                  state <= S_CALC;
                end
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end

        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              acc_h <= div_ok ? div_diff : div_shift[W-1:0];
              acc_l <= {acc_l[W-2:0], div_ok};
            end else begin
              {acc_h, acc_l} <= {mul_sum, acc_l[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) state <= S_FIX;
          end
        end

        S_FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (W=32): mul/div results, latency,
// divide-by-zero, flush, same-edge conflicts and mid-operation reset.
module tb_mdu_seq;

  localparam int W = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   mdu_op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_seq #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request across exactly one rising edge (the issue edge E0).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = OP_NOP;
  endtask

  // Issue a mul/div and watch a bounded window: busy length, single done pulse,
  // done arriving the cycle after busy drops, and the HI/LO values at done.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_busy);
    int busy_cycles = 0;
    int done_cnt    = 0;
    int done_idx    = 0;
    int overlap     = 0;
    logic [W-1:0] hi_at_done = '0;
    logic [W-1:0] lo_at_done = '0;
    issue(op, a, b);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done && busy) overlap++;
      if (done) begin
        done_cnt++;
        done_idx   = k;
        hi_at_done = hi;
        lo_at_done = lo;
      end
    end
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    check({tag, " done_count"},  64'(done_cnt),    64'd1);
    check({tag, " done_cycle"},  64'(done_idx),    64'(exp_busy + 1));
    check({tag, " done_busy_overlap"}, 64'(overlap), 64'd0);
    check({tag, " hi"}, 64'(hi_at_done), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_at_done), 64'(exp_lo));
  endtask

  initial begin
    int done_seen;
    rst    = 1'b1;
    start  = 1'b0;
    mdu_op = OP_NOP;
    rs_val = '0;
    rt_val = '0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);

    // Multiply and divide results with full W+1 cycle busy window
    run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_negrt",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("divu",       OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33);
    run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_zero",  OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1);
    run_op("div_zero",   OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);

    // MTHI / MTLO preload
    issue(OP_MTHI, 32'hAA, 32'd0);
    issue(OP_MTLO, 32'hBB, 32'd0);
    @(negedge clk);
    check("mt busy", 64'(busy), 64'd0);
    check("mt done", 64'(done), 64'd0);
    check("mthi hi", 64'(hi),   64'hAA);
    check("mtlo lo", 64'(lo),   64'hBB);

    // MULT flushed mid-flight; an MTLO while busy must be dropped
    issue(OP_MULT, 32'd1234, 32'd5678);
    issue(OP_MTLO, 32'h1234, 32'd0);
    repeat (8) @(negedge clk);
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("flush no_done", 64'(done_seen), 64'd0);
    check("flush hi", 64'(hi), 64'hAA);
    check("flush lo", 64'(lo), 64'hBB);

    issue(OP_MTHI, 32'h55, 32'd0);
    @(negedge clk);
    check("mthi55 busy", 64'(busy), 64'd0);
    check("mthi55 hi",   64'(hi),   64'h55);
    check("mthi55 lo",   64'(lo),   64'hBB);

    // Same-edge flush in IDLE suppresses both mul/div issue and MT writes
    flush = 1'b1;
    issue(OP_MULT, 32'd3, 32'd3);
    issue(OP_MTHI, 32'h77, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle busy", 64'(busy), 64'd0);
    check("flush_idle hi",   64'(hi),   64'h55);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("flush_idle quiet", 64'(done_seen), 64'd0);
    check("flush_idle lo",    64'(lo),        64'hBB);

    // Reset (together with flush) mid-DIV aborts and clears HI/LO
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    check("rst pre busy", 64'(busy), 64'd1);
    rst   = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid hi",   64'(hi),   64'd0);
    check("rst_mid lo",   64'(lo),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
